// File: rtl/game_ctrl.sv
// Pong match sequencer: serve/play/point/game-over on the game tick, paddle hit/miss at the edge columns, scoring.
// All outputs registered; changes appear one clk after the qualifying tick or serve-button press.
module game_ctrl #(
    parameter int BASE_SPEED  = 4,
    parameter int MAX_SPEED   = 15,
    parameter int PADDLE_LEN  = 4,
    parameter int SERVE_TICKS = 500,
    parameter int POINT_TICKS = 1000,
    parameter int WIN_SCORE   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_serve,
    input  logic [3:0] ball_x,
    input  logic [3:0] ball_y,
    input  logic [3:0] paddle_l,
    input  logic [3:0] paddle_r,
    output logic       ball_reset,
    output logic [4:0] ball_speed,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] state,
    output logic       winner,
    output logic       hit
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SERVE    = 3'd1;
    localparam logic [2:0] S_PLAY     = 3'd2;
    localparam logic [2:0] S_POINT    = 3'd3;
    localparam logic [2:0] S_GAMEOVER = 3'd4;

    localparam int CMAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_TICKS - 1);
    localparam logic [CW-1:0] POINT_LAST = CW'(POINT_TICKS - 1);
    localparam logic [4:0] SPD_POS = 5'(BASE_SPEED);
    localparam logic [4:0] SPD_NEG = ~SPD_POS + 5'd1;
    localparam logic [4:0] MAX5    = 5'(MAX_SPEED);
    localparam logic [4:0] LEN_M1  = 5'(PADDLE_LEN - 1);
    localparam logic [3:0] WIN4    = 4'(WIN_SCORE);

    logic [2:0]    r_state;
    logic          r_ball_reset;
    logic [4:0]    r_speed;
    logic [3:0]    r_score_l;
    logic [3:0]    r_score_r;
    logic          r_winner;
    logic          r_hit;
    logic          r_btn_prev;
    logic [CW-1:0] r_cnt;

    logic       w_press;
    logic [4:0] w_mag;
    logic [4:0] w_mag_inc;
    logic [4:0] w_mag_new;
    logic [4:0] w_spd_hit;
    logic       w_at_left;
    logic       w_at_right;
    logic [4:0] w_pad_lo;
    logic [4:0] w_pad_hi;
    logic [4:0] w_y;
    logic       w_in_pad;

    assign w_press    = btn_serve & ~r_btn_prev;
    assign w_mag      = r_speed[4] ? (~r_speed + 5'd1) : r_speed;
    assign w_mag_inc  = w_mag + 5'd1;
    assign w_mag_new  = (w_mag_inc > MAX5) ? MAX5 : w_mag_inc;
    assign w_spd_hit  = r_speed[4] ? w_mag_new : (~w_mag_new + 5'd1);
    assign w_at_left  = (ball_x == 4'd0) && r_speed[4];
    assign w_at_right = (ball_x == 4'd15) && !r_speed[4] && (r_speed != 5'd0);
    // Paddle span is 5 bits wide so a paddle near the bottom row extends past 15 instead of wrapping to the top.
    assign w_pad_lo   = {1'b0, (w_at_left ? paddle_l : paddle_r)};
    assign w_pad_hi   = w_pad_lo + LEN_M1;
    assign w_y        = {1'b0, ball_y};
    assign w_in_pad   = (w_y >= w_pad_lo) && (w_y <= w_pad_hi);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ball_reset <= 1'b1;
            r_speed      <= SPD_POS;
            r_score_l    <= 4'd0;
            r_score_r    <= 4'd0;
            r_winner     <= 1'b0;
            r_hit        <= 1'b0;
            r_btn_prev   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_btn_prev <= btn_serve;
            r_hit      <= 1'b0;
            case (r_state)
                S_IDLE, S_GAMEOVER: begin
                    if (w_press) begin
                        r_state   <= S_SERVE;
                        r_score_l <= 4'd0;
                        r_score_r <= 4'd0;
                        r_speed   <= SPD_POS;
                        r_cnt     <= '0;
                    end
                end
                S_SERVE: begin
                    if (tick) begin
                        if (r_cnt == SERVE_LAST) begin
                            r_state      <= S_PLAY;
                            r_ball_reset <= 1'b0;
                            r_cnt        <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    // Only the edge the ball is moving toward is checked, so a reversed ball cannot retrigger.
                    if (tick && (w_at_left || w_at_right)) begin
                        if (w_in_pad) begin
                            r_speed <= w_spd_hit;
                            r_hit   <= 1'b1;
                        end else begin
                            r_state      <= S_POINT;
                            r_ball_reset <= 1'b1;
                            r_cnt        <= '0;
                            if (w_at_left) begin
                                r_score_r <= r_score_r + 4'd1;
                                r_speed   <= SPD_NEG;
                            end else begin
                                r_score_l <= r_score_l + 4'd1;
                                r_speed   <= SPD_POS;
                            end
                        end
                    end
                end
                S_POINT: begin
                    if (tick) begin
                        if (r_cnt == POINT_LAST) begin
                            r_cnt <= '0;
                            if (r_score_l == WIN4 || r_score_r == WIN4) begin
                                r_state  <= S_GAMEOVER;
                                r_winner <= (r_score_r == WIN4);
                            end else begin
                                r_state <= S_SERVE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_ball_reset <= 1'b1;
                end
            endcase
        end
    end

    assign state      = r_state;
    assign ball_reset = r_ball_reset;
    assign ball_speed = r_speed;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign winner     = r_winner;
    assign hit        = r_hit;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Game sequencer for the pong datapath. Runs the match state machine (idle, serve, play, point, game over) on the 1 kHz game tick, and drives the ball block's reset and signed speed. Detects paddle hits and misses at the edge columns of the 16x16 matrix, keeps both scores and declares a winner. Sits between the game clock divider, the ball block, the paddle inputs and the screen.

Parameters:
BASE_SPEED, 4, serve speed magnitude (1..15)
MAX_SPEED, 15, speed magnitude ceiling (BASE_SPEED..15)
PADDLE_LEN, 4, paddle height in rows (1..16)
SERVE_TICKS, 500, ticks the ball is held at reset before play starts
POINT_TICKS, 1000, ticks of pause after a point
WIN_SCORE, 9, score that ends the match (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
tick  in  1  one-clk-wide game tick enable (1 kHz)
btn_serve  in  1  serve/restart button, synchronous level
ball_x  in  4  ball column, 0 = left edge, 15 = right edge
ball_y  in  4  ball row
paddle_l  in  4  top row of left paddle
paddle_r  in  4  top row of right paddle
ball_reset  out  1  holds ball block at centre when 1
ball_speed  out  5  signed ball speed; sign = x direction (negative = leftward)
score_l  out  4  left score
score_r  out  4  right score
state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 GAMEOVER
winner  out  1  0 = left, 1 = right; valid in GAMEOVER
hit  out  1  one-clk pulse on paddle hit

Behaviour:
- Reset (reset=0, async): state=IDLE, ball_reset=1, ball_speed=+BASE_SPEED, scores=0, winner=0, hit=0, tick counter=0, button edge register=0.
- btn_serve edge detect: registered previous value. press = btn_serve & ~prev, evaluated every clk, not gated by tick.
- IDLE: ball_reset=1. On press: scores cleared, ball_speed=+BASE_SPEED, counter=0, go to SERVE on the next clk.
- SERVE: ball_reset=1. Counter increments on tick. When a tick arrives with counter==SERVE_TICKS-1, go to PLAY and clear the counter.
- PLAY: ball_reset=0. Edge checks are made only on tick cycles, at most one per tick.
  - Left check: ball_x==0 and ball_speed<0. Hit if paddle_l <= ball_y <= paddle_l+PADDLE_LEN-1. This sum is computed at 5 bits, so a paddle near the bottom is not wrapped.
  - Right check: ball_x==15 and ball_speed>0, against paddle_r with the same rule.
  - On a hit: magnitude = min(|speed|+1, MAX_SPEED); sign is reversed; hit pulses for 1 clk. After the reversal, the same edge cannot retrigger.
  - On a miss: the opponent's score increments; counter clears; go to POINT. Next serve direction points toward the player who conceded: a left miss gives -BASE_SPEED, a right miss gives +BASE_SPEED. This value is loaded into ball_speed now.
  - ball_speed==0 never occurs; the magnitude is always >= 1.
- POINT: ball_reset=1. Counter increments on tick. At the end of POINT_TICKS:
  - if either score==WIN_SCORE, go to GAMEOVER with winner = the player who scored;
  - else go to SERVE with counter cleared.
- GAMEOVER: ball_reset=1, scores held. A press behaves exactly as a press in IDLE (scores cleared, go to SERVE).
- Presses in SERVE, PLAY and POINT are ignored.
- Scores never exceed WIN_SCORE: the increment happens only in PLAY, and WIN_SCORE terminates the match.
- All outputs are registered. State and output changes appear 1 clk after the qualifying tick or press.
- Asynchronous reset mid-match returns to IDLE immediately and discards scores.

Test Plan:
- Reset then press in IDLE -> state SERVE next clk, ball_reset=1, ball_speed=+4. After 500 ticks -> PLAY, ball_reset=0.
- PLAY with speed=+4, ball_x=15, ball_y=7, paddle_r=5 (LEN 4), tick -> hit pulse 1 clk, ball_speed=-5, state PLAY. Repeat at speed ±15 -> magnitude stays 15, sign flips.
- PLAY with speed=-6, ball_x=0, ball_y=2, paddle_l=8, tick -> score_r=1, state POINT, ball_speed=-4, ball_reset=1. After 1000 ticks -> SERVE.
- paddle_l=14, ball_y=15, x=0, speed<0 -> hit (5-bit range 14..17, no wrap). Same setup with ball_y=0 -> miss.
- score_l=8, right miss -> POINT then GAMEOVER, winner=0. Press held for many clks -> exactly one restart: scores 0, SERVE. Press during PLAY -> no effect.
- Assert reset low mid-PLAY, asynchronously between clk edges -> outputs show IDLE values immediately; hit/score activity stops until the next press.
